// File: rtl/synth_audio_pkg.sv
// Shared audio types: stereo sample container, I2S receiver states and framing constants.
package synth_audio_pkg;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_sample_t;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, HOLD} i2s_rx_state_t;

  // I2S places the MSB one bit clock after the word-clock edge
  localparam int I2S_DATA_DELAY = 1;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous pad with rise/fall detection on the synchronised level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_reg;
  logic                   q_prev_reg;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      chain_reg  <= '0;
      q_prev_reg <= 1'b0;
    end else begin
      chain_reg  <= {chain_reg[SYNC_STAGES-2:0], d};
      q_prev_reg <= chain_reg[SYNC_STAGES-1];
    end
  end

  // Edges are combinational so a shift can act on the very cycle the edge is seen
  assign q    = chain_reg[SYNC_STAGES-1];
  assign rise = q & ~q_prev_reg;
  assign fall = ~q & q_prev_reg;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: deserialises left/right words from the codec port and presents
// them as one stereo frame on a valid/ready handshake with a single-entry output register.
module i2s_adc_receiver
  import synth_audio_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                enable,
  input  logic                AUD_BCLK,
  input  logic                AUD_ADCLRCK,
  input  logic                AUD_ADCDAT,
  output logic [SAMPLE_W-1:0] LDATA_out,
  output logic [SAMPLE_W-1:0] RDATA_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                frame_err
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic bclk_q, bclk_rise, bclk_fall;
  logic lr_q, lr_rise, lr_fall;
  logic dat_sync, dat_rise, dat_fall;
  logic sync_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .Clk(Clk), .Reset_n(Reset_n), .d(AUD_BCLK),
    .q(bclk_q), .rise(bclk_rise), .fall(bclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .Clk(Clk), .Reset_n(Reset_n), .d(AUD_ADCLRCK),
    .q(lr_q), .rise(lr_rise), .fall(lr_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .Clk(Clk), .Reset_n(Reset_n), .d(AUD_ADCDAT),
    .q(dat_sync), .rise(dat_rise), .fall(dat_fall)
  );

  assign sync_unused = bclk_q ^ bclk_fall ^ lr_q ^ dat_rise ^ dat_fall;

  i2s_rx_state_t       state_reg, state_next;
  logic                ch_r_reg, ch_r_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic [SAMPLE_W-1:0] shreg_reg, shreg_next, shifted;
  logic [SAMPLE_W-1:0] left_pend_reg, left_pend_next;
  logic                commit_reg, commit_next;
  logic                frame_err_reg, frame_err_next;
  logic [SAMPLE_W-1:0] ldata_reg, rdata_reg;
  logic                valid_reg, overrun_reg;

  assign cnt_inc = cnt_reg + CNT_W'(1);
  assign shifted = {shreg_reg[SAMPLE_W-2:0], dat_sync};

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      ch_r_reg      <= 1'b0;
      cnt_reg       <= '0;
      shreg_reg     <= '0;
      left_pend_reg <= '0;
      commit_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ch_r_reg      <= ch_r_next;
      cnt_reg       <= cnt_next;
      shreg_reg     <= shreg_next;
      left_pend_reg <= left_pend_next;
      commit_reg    <= commit_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ch_r_next      = ch_r_reg;
    cnt_next       = cnt_reg;
    shreg_next     = shreg_reg;
    left_pend_next = left_pend_reg;
    commit_next    = 1'b0;
    frame_err_next = 1'b0;
    if (!enable) begin
      state_next     = IDLE;
      left_pend_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lr_fall) begin
            state_next = DELAY;
            ch_r_next  = 1'b0;
            cnt_next   = '0;
          end
        end
        DELAY, SHIFT: begin
          // A word-clock edge before the word is complete means a short channel
          if (lr_fall || lr_rise) begin
            frame_err_next = 1'b1;
            if (ch_r_reg) left_pend_next = '0;
            if (lr_fall) begin
              state_next = DELAY;
              ch_r_next  = 1'b0;
              cnt_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else if (bclk_rise) begin
            if (state_reg == DELAY) begin
              if (cnt_reg == CNT_W'(I2S_DATA_DELAY - 1)) begin
                state_next = SHIFT;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_inc;
              end
            end else begin
              shreg_next = shifted;
              cnt_next   = cnt_inc;
              if (cnt_inc == CNT_W'(SAMPLE_W)) begin
                state_next = HOLD;
                if (ch_r_reg) commit_next = 1'b1;
                else          left_pend_next = shifted;
              end
            end
          end
        end
        HOLD: begin
          if (lr_rise && !ch_r_reg) begin
            state_next = DELAY;
            ch_r_next  = 1'b1;
            cnt_next   = '0;
          end else if (lr_fall && ch_r_reg) begin
            state_next = DELAY;
            ch_r_next  = 1'b0;
            cnt_next   = '0;
          end else if (lr_rise || lr_fall) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Single-entry output register; a held, unaccepted frame wins over a new one
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ldata_reg   <= '0;
      rdata_reg   <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (commit_reg) begin
      if (valid_reg && !sample_ready) begin
        overrun_reg <= 1'b1;
      end else begin
        ldata_reg <= left_pend_reg;
        rdata_reg <= shreg_reg;
        valid_reg <= 1'b1;
      end
    end else if (valid_reg && sample_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign LDATA_out    = ldata_reg;
  assign RDATA_out    = rdata_reg;
  assign sample_valid = valid_reg;
  assign overrun      = overrun_reg;
  assign frame_err    = frame_err_reg;

endmodule
